// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the instruction-fetch slice of the pipeline.
//
// Contents:
//   INST_NOP       instruction word used for fault entries (all zeros)
//   IFQ_DEPTH      number of entries in the fetch-to-decode queue
//   fetch_state_t  fetch FSM state encoding (BOOT, FETCH, HALT)
//   ifq_entry_t    one queue entry: {inst, pc4, fault}
//   next_seq_pc    sequential next-PC helper (pc + 4, wraps modulo 2^32)
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0000;
    localparam int          IFQ_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        fault;
    } ifq_entry_t;

    // Plain 32-bit addition; the carry out of bit 31 is dropped on purpose
    // so that fetching at 0xFFFFFFFC wraps to address 0.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_ifq.sv
// ----------------------------------------------------------------------------
// pipe_ifq
//
// Small circular queue between instruction fetch and decode. The head entry
// is presented combinationally from storage; writes and reads take effect on
// the rising clock edge. Occupancy is tracked with an explicit count so that
// full and empty are never confused when the pointers are equal.
//
// Parameters:
//   DEPTH      number of entries (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset (pointers, count and storage)
//   i_clear    synchronous clear of pointers and count (dominates wr/rd)
//   i_wrEn     write request; ignored when full unless a read happens too
//   i_wrData   entry to write
//   i_rdEn     read request; ignored when empty
//   o_head     entry at the read pointer
//   o_empty    no valid entries
//   o_full     DEPTH valid entries
// ----------------------------------------------------------------------------
module pipe_ifq
    import pipe_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_clear,
    input  logic       i_wrEn,
    input  ifq_entry_t i_wrData,
    input  logic       i_rdEn,
    output ifq_entry_t o_head,
    output logic       o_empty,
    output logic       o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    ifq_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic w_doWrite;
    logic w_doRead;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths also work.
    function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    // A write into a full queue is allowed only when the head leaves in the
    // same cycle, which keeps occupancy unchanged.
    assign w_doRead  = i_rdEn & ~o_empty;
    assign w_doWrite = i_wrEn & (~o_full | w_doRead);

    assign o_head = r_mem[r_rdPtr];

    // Pointer and occupancy bookkeeping. A clear drops every entry at once;
    // storage is left untouched because empty entries are never observed
    // as valid.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= bumpPtr(r_wrPtr);
            end
            if (w_doRead) begin
                r_rdPtr <= bumpPtr(r_rdPtr);
            end
            case ({w_doWrite, w_doRead})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage. Reset to zero so the head reads as all-zero out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doWrite && !i_clear) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

endmodule

// File: rtl/pipe_ifetch.sv
// ----------------------------------------------------------------------------
// pipe_ifetch
//
// Instruction fetch stage. Issues requests to instruction memory at the
// address held by the external PC register, steers the PC register through
// o_wpc, and buffers fetched instructions in a two-entry queue (pipe_ifq)
// whose head is offered to decode. A misaligned PC produces a single fault
// entry and parks the stage in HALT until a redirect (i_flush) arrives.
//
// Optional feature (compile-time macro IFETCH_BYPASS_EN):
//   defined   - when the queue is empty and decode is ready, an accepted
//               fetch goes straight to the decode outputs in the same cycle
//               and is not written into the queue.
//   undefined - every fetched instruction passes through the queue; it
//               appears on the decode outputs one cycle after the fetch.
//
// Ports:
//   clk           rising-edge clock shared with the PC register
//   clrn          asynchronous active-low reset
//   i_pc          current fetch address from the PC register
//   i_flush       branch/jump redirect (PC register loads target this edge)
//   o_wpc         PC register write enable
//   o_pc4         i_pc + 4, sequential next-PC candidate
//   o_imem_req    instruction memory request
//   o_imem_addr   instruction memory address (= i_pc)
//   i_imem_ack    request accepted this cycle
//   i_imem_rdata  instruction word, valid with i_imem_ack
//   o_d_valid     decode entry valid
//   o_d_inst      decode entry instruction
//   o_d_pc4       decode entry pc + 4
//   o_d_fault     decode entry marks a misaligned fetch
//   i_d_ready     decode accepts the head entry when o_d_valid is high
// ----------------------------------------------------------------------------
module pipe_ifetch
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_wpc,
    output logic [31:0] o_pc4,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_d_valid,
    output logic [31:0] o_d_inst,
    output logic [31:0] o_d_pc4,
    output logic        o_d_fault,
    input  logic        i_d_ready
);

    fetch_state_t r_state;

    ifq_entry_t w_ifqHead;
    logic       w_ifqEmpty;
    logic       w_ifqFull;

    logic [31:0] w_pc4;
    logic        w_misaligned;
    logic        w_headTaken;
    logic        w_room;
    logic        w_imemReq;
    logic        w_accept;
    logic        w_faultPush;
    logic        w_bypass;
    logic        w_push;
    ifq_entry_t  w_fetchEntry;
    ifq_entry_t  w_faultEntry;
    ifq_entry_t  w_pushData;

    assign w_pc4        = next_seq_pc(i_pc);
    assign w_misaligned = |i_pc[1:0];

    // Decode takes the stored head whenever one is present and it is ready.
    assign w_headTaken = ~w_ifqEmpty & i_d_ready;

    // A full queue still has room if its head leaves in the same cycle.
    assign w_room = ~w_ifqFull | w_headTaken;

    // Memory request: only in FETCH with an aligned PC, no redirect pending
    // and somewhere to put the result. It must react to i_flush within the
    // same cycle, so it is decoded from the registered state rather than
    // registered itself.
    always_comb begin
        w_imemReq = 1'b0;
        if ((r_state == ST_FETCH) && !i_flush && !w_misaligned && w_room) begin
            w_imemReq = 1'b1;
        end
    end

    assign w_accept = w_imemReq & i_imem_ack;

    // A misaligned PC never reaches memory; it is reported once as a fault
    // entry as soon as the queue can take it, and the FSM then parks in HALT.
    assign w_faultPush = (r_state == ST_FETCH) & ~i_flush & w_misaligned & w_room;

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_ifqEmpty & i_d_ready & w_accept;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fetchEntry = '{inst: i_imem_rdata, pc4: w_pc4, fault: 1'b0};
    assign w_faultEntry = '{inst: INST_NOP,     pc4: w_pc4, fault: 1'b1};

    // Accepted fetch and fault entry are mutually exclusive (aligned versus
    // misaligned PC), so a single write port suffices.
    assign w_push     = (w_accept & ~w_bypass) | w_faultPush;
    assign w_pushData = w_faultPush ? w_faultEntry : w_fetchEntry;

    pipe_ifq #(
        .DEPTH (IFQ_DEPTH)
    ) u_ifq (
        .clk      (clk),
        .clrn     (clrn),
        .i_clear  (i_flush),
        .i_wrEn   (w_push),
        .i_wrData (w_pushData),
        .i_rdEn   (w_headTaken),
        .o_head   (w_ifqHead),
        .o_empty  (w_ifqEmpty),
        .o_full   (w_ifqFull)
    );

    // Fetch FSM. A redirect wins over everything and always lands in FETCH,
    // which also releases a HALT caused by a misaligned PC.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_BOOT;
        end else if (i_flush) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_BOOT:  r_state <= ST_FETCH;
                ST_FETCH: r_state <= w_faultPush ? ST_HALT : ST_FETCH;
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_BOOT;
            endcase
        end
    end

    // The PC register advances on an accepted fetch and loads the redirect
    // target on a flush; in HALT no fetch is accepted so only a flush moves it.
    assign o_wpc       = w_accept | i_flush;
    assign o_pc4       = w_pc4;
    assign o_imem_req  = w_imemReq;
    assign o_imem_addr = i_pc;

    // With bypass active the just-fetched word is shown directly; d_valid then
    // depends combinationally on i_d_ready, which decode must not loop back.
    assign o_d_valid = ~w_ifqEmpty | w_bypass;
    assign o_d_inst  = w_bypass ? w_fetchEntry.inst  : w_ifqHead.inst;
    assign o_d_pc4   = w_bypass ? w_fetchEntry.pc4   : w_ifqHead.pc4;
    assign o_d_fault = w_bypass ? w_fetchEntry.fault : w_ifqHead.fault;

endmodule

// File: tb/tb_pipe_ifetch.sv
// ----------------------------------------------------------------------------
// tb_pipe_ifetch
//
// Self-checking bench for pipe_ifetch. A behavioural model (a queue of
// expected decode entries plus boot/halt flags and the PC register) predicts
// every output each cycle. Directed scenarios come first (boot, back-pressure,
// flush while full, misaligned PC, reset mid-request), then randomized cycles.
// ----------------------------------------------------------------------------
module tb_pipe_ifetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        fault;
    } tbEntry_t;

    logic        clk;
    logic        clrn;
    logic [31:0] pc;
    logic        flush;
    logic        wpc;
    logic [31:0] pc4;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        dValid;
    logic [31:0] dInst;
    logic [31:0] dPc4;
    logic        dFault;
    logic        dReady;

    int nVectors    = 0;
    int nMiscompares = 0;

    // Reference model state.
    tbEntry_t    mQ[$];
    bit          mBoot;
    bit          mHalt;
    logic [31:0] mPc;

    pipe_ifetch dut (
        .clk          (clk),
        .clrn         (clrn),
        .i_pc         (pc),
        .i_flush      (flush),
        .o_wpc        (wpc),
        .o_pc4        (pc4),
        .o_imem_req   (imemReq),
        .o_imem_addr  (imemAddr),
        .i_imem_ack   (imemAck),
        .i_imem_rdata (imemRdata),
        .o_d_valid    (dValid),
        .o_d_inst     (dInst),
        .o_d_pc4      (dPc4),
        .o_d_fault    (dFault),
        .i_d_ready    (dReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Asserts reset away from any clock edge, checks that outputs fall to
    // their reset values without a clock, then releases just after an edge.
    task automatic doReset();
        flush  = 1'b0;
        clrn   = 1'b0;
        #1;
        checkOutput("rst_req",    32'(imemReq), 32'd0);
        checkOutput("rst_wpc",    32'(wpc),     32'd0);
        checkOutput("rst_dvalid", 32'(dValid),  32'd0);
        checkOutput("rst_dinst",  dInst,        32'd0);
        checkOutput("rst_dpc4",   dPc4,         32'd0);
        checkOutput("rst_dfault", 32'(dFault),  32'd0);
        @(posedge clk);
        #1;
        clrn  = 1'b1;
        mQ.delete();
        mBoot = 1'b1;
        mHalt = 1'b0;
        mPc   = 32'd0;
    endtask

    // One clock cycle: drive inputs shortly after the edge, predict and check
    // outputs mid-cycle, then advance the model across the next rising edge.
    task automatic applyStimulus(input bit f, input logic [31:0] target,
                                 input bit a, input logic [31:0] rd, input bit dr);
        bit room, inFetch, expReq, acc, byp, expWpc, expValid;
        flush     = f;
        imemAck   = a;
        imemRdata = rd;
        dReady    = dr;
        pc        = mPc;
        #2;
        room     = (mQ.size() < 2) || (dr && mQ.size() > 0);
        inFetch  = !mBoot && !mHalt;
        expReq   = inFetch && !f && (mPc[1:0] == 2'b00) && room;
        acc      = expReq && a;
`ifdef IFETCH_BYPASS_EN
        byp      = acc && dr && (mQ.size() == 0);
`else
        byp      = 1'b0;
`endif
        expWpc   = acc || f;
        expValid = (mQ.size() > 0) || byp;

        checkOutput("req",    32'(imemReq), 32'(expReq));
        checkOutput("addr",   imemAddr,     mPc);
        checkOutput("pc4",    pc4,          mPc + 32'd4);
        checkOutput("wpc",    32'(wpc),     32'(expWpc));
        checkOutput("dvalid", 32'(dValid),  32'(expValid));
        if (byp) begin
            checkOutput("byp_dinst",  dInst,       rd);
            checkOutput("byp_dpc4",   dPc4,        mPc + 32'd4);
            checkOutput("byp_dfault", 32'(dFault), 32'd0);
        end else if (mQ.size() > 0) begin
            checkOutput("dinst",  dInst,       mQ[0].inst);
            checkOutput("dpc4",   dPc4,        mQ[0].pc4);
            checkOutput("dfault", 32'(dFault), 32'(mQ[0].fault));
        end

        @(posedge clk);
        if (f) begin
            mQ.delete();
            mBoot = 1'b0;
            mHalt = 1'b0;
        end else begin
            if (dr && mQ.size() > 0) begin
                void'(mQ.pop_front());
            end
            if (acc && !byp) begin
                mQ.push_back('{inst: rd, pc4: mPc + 32'd4, fault: 1'b0});
            end
            if (inFetch && (mPc[1:0] != 2'b00) && room) begin
                mQ.push_back('{inst: 32'h0, pc4: mPc + 32'd4, fault: 1'b1});
                mHalt = 1'b1;
            end
            mBoot = 1'b0;
        end
        if (f) begin
            mPc = target;
        end else if (expWpc) begin
            mPc = mPc + 32'd4;
        end
        #1;
    endtask

    initial begin
        bit          f;
        bit          a;
        bit          dr;
        logic [31:0] target;

        clrn      = 1'b0;
        pc        = 32'd0;
        flush     = 1'b0;
        imemAck   = 1'b0;
        imemRdata = 32'd0;
        dReady    = 1'b0;
        mQ.delete();
        mBoot     = 1'b1;
        mHalt     = 1'b0;
        mPc       = 32'd0;

        $display("[TB] reset and boot");
        doReset();

        // Boot cycle, first fetch at pc=0, then the entry reaches decode.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'h2008_0005, 1'b1);
        end

        $display("[TB] decode back-pressure then drain");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'h1111_0000 + 32'(i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        end

        $display("[TB] flush while full with ack");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'h2222_0000 + 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 32'hBAD0_BAD0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        $display("[TB] misaligned pc and halt");
        applyStimulus(1'b1, 32'h0000_0006, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'h3333_0000, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'h3333_0001, 1'b1);
        end
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 32'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 32'h4444_0000 + 32'(i), 1'b1);
        end

        $display("[TB] reset during outstanding request");
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'd0, 1'b0);
        flush   = 1'b0;
        imemAck = 1'b0;
        dReady  = 1'b0;
        pc      = mPc;
        #2;
        checkOutput("pre_rst_req", 32'(imemReq), 32'd1);
        doReset();
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h5555_0000, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            f  = ($urandom_range(0, 15) == 0);
            a  = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 4) < 3);
            target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) begin
                target[1:0] = 2'($urandom_range(1, 3));
            end
            applyStimulus(f, target, a, $urandom, dr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
